dmem_responder: RTL and testbench

Responder end of the processor's data-memory request interface: accepts one load/store request at a time over a valid/ready handshake, services it after a programmable wait-state count, and returns a single-cycle response carrying read data and an error flag. It sits between the core's load/store path and word storage, replacing the zero-latency data memory when multi-cycle memory timing must be modelled. It also checks alignment and range for every access.

---
 rtl/mips_bus_pkg.sv | 7 +
 rtl/dmem_word_array.sv | 21 ++
 rtl/dmem_responder.sv | 77 +++++++
 tb/tb_dmem_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared types and constants for the data-memory request bus.
package mips_bus_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int WORD_BYTES = 4;
    localparam int DEFAULT_LATENCY = 2;
    localparam int BE_WIDTH = WORD_BYTES;
endpackage

// File: rtl/dmem_word_array.sv
// dmem_word_array: word storage with one synchronous byte-maskable port; read returns pre-write contents.
module dmem_word_array
    import mips_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [BE_WIDTH-1:0]   be,
    input  logic [ADDR_WIDTH-1:0] index,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);
    logic [31:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_WIDTH; i++)
            if (we && be[i]) mem_q[index][8*i +: 8] <= wdata[8*i +: 8];
        rdata <= mem_q[index];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with programmable wait states,
// alignment/range checking and a single-cycle response pulse.
module dmem_responder
    import mips_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = DEFAULT_LATENCY
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    input  logic [BE_WIDTH-1:0] req_be,
    output logic                rsp_valid,
    output logic [31:0]         rsp_rdata,
    output logic                rsp_err
);
    state_t              state_q, state_d;
    logic [3:0]          cnt_q;
    logic                write_q, err_q, ld_q, access, err;
    logic [31:0]         addr_q, wdata_q, rdata_q, mem_rdata;
    logic [BE_WIDTH-1:0] be_q;

    always_comb begin
        access    = state_q == WAIT && cnt_q == 4'd0;
        err       = addr_q[1:0] != 2'b00 || (addr_q >> (ADDR_WIDTH + 2)) != 32'd0;
        req_ready = state_q == IDLE;
        rsp_valid = state_q == RESP;
        state_d   = state_q == IDLE ? (req_valid ? WAIT : IDLE)
                  : state_q == WAIT ? (access ? RESP : WAIT) : IDLE;
        // Array data is only meaningful in RESP; afterwards the latched copy is held.
        rsp_rdata = rsp_valid ? (ld_q ? mem_rdata : 32'd0) : rdata_q;
        rsp_err   = err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= '0;
            err_q   <= 1'b0;
            ld_q    <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (req_ready && req_valid) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
                cnt_q   <= 4'(LATENCY);
            end else if (state_q == WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (access) begin
                err_q <= err;
                ld_q  <= !write_q && !err;
            end
            if (rsp_valid) rdata_q <= rsp_rdata;
        end
    end

    dmem_word_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
        .clk   (clk),
        .we    (access && write_q && !err),
        .be    (be_q),
        .index (addr_q[ADDR_WIDTH+1:2]),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of two responders (LATENCY 2 and 0)
// against a byte-level storage model.
module tb_dmem_responder;
    localparam int AW = 8;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst_s     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    logic [7:0]  mb [2][DEPTH][4];
    bit          kn [2][DEPTH][4];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(2)) u_dut2 (
        .clk(clk), .reset(rst_s[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_be(req_be[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(rst_s[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_be(req_be[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    function automatic int lat(input int d);
        return d == 0 ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] got);
        int  c, idx;
        bit  e;
        @(negedge clk);
        check("ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1; req_write[d] = w; req_addr[d] = a; req_wdata[d] = wd; req_be[d] = be;
        @(negedge clk);
        c = 1;
        // Busy-time noise: these must all be ignored.
        while (rsp_valid[d] !== 1'b1 && c < 40) begin
            req_valid[d] = 1'($urandom_range(0, 1));
            req_write[d] = 1'b1; req_addr[d] = 32'd0; req_wdata[d] = $urandom(); req_be[d] = 4'hF;
            @(negedge clk);
            c++;
        end
        req_valid[d] = 1'b0;
        check("latency", 32'(c), 32'(lat(d) + 2));
        e = (a % 4 != 0) || (a >= 32'(4 * DEPTH));
        idx = e ? 0 : int'(a / 4);
        got = rsp_rdata[d];
        check("err", 32'(rsp_err[d]), 32'(e));
        if (w || e) check("rdata_zero", got, 32'd0);
        else for (int b = 0; b < 4; b++)
            if (kn[d][idx][b]) check("rdata", 32'(got[8*b +: 8]), 32'(mb[d][idx][b]));
        if (w && !e) for (int b = 0; b < 4; b++)
            if (be[b]) begin mb[d][idx][b] = wd[8*b +: 8]; kn[d][idx][b] = 1'b1; end
        @(negedge clk);
        check("ready_back", 32'(req_ready[d]), 32'd1);
        check("pulse_len", 32'(rsp_valid[d]), 32'd0);
        check("hold_rdata", rsp_rdata[d], got);
        check("hold_err", 32'(rsp_err[d]), 32'(e));
    endtask

    initial begin
        logic [31:0] g, a;
        int acc, rsps, last, seen;
        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0; req_be[d] = 4'd0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", 32'(req_ready[d]), 32'd1);
            check("rst_valid", 32'(rsp_valid[d]), 32'd0);
            check("rst_rdata", rsp_rdata[d], 32'd0);
            check("rst_err", 32'(rsp_err[d]), 32'd0);
            rst_s[d] = 1'b0;
        end

        txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, g);
        txn(0, 0, 32'h10, 32'h0, 4'h0, g);
        check("load_deadbeef", g, 32'hDEADBEEF);
        txn(0, 1, 32'h20, 32'h11223344, 4'hF, g);
        txn(0, 1, 32'h20, 32'hAABBCCDD, 4'h5, g);
        txn(0, 0, 32'h20, 32'h0, 4'hF, g);
        check("be_merge", g, 32'h11BB33DD);
        txn(0, 0, 32'h22, 32'h0, 4'hF, g);
        txn(0, 1, 32'h0, 32'h5A5A5A5A, 4'hF, g);
        txn(0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, g);
        txn(0, 0, 32'h0, 32'h0, 4'h0, g);
        check("oor_no_write", g, 32'h5A5A5A5A);
        txn(0, 1, 32'h20, 32'h99999999, 4'h0, g);
        txn(0, 0, 32'h20, 32'h0, 4'h0, g);
        check("be_zero", g, 32'h11BB33DD);

        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h10; req_be[0] = 4'h0;
        acc = 0; rsps = 0; last = 0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready[0]) begin
                if (acc > 0) check("b2b_gap", 32'(i - last), 32'd5);
                acc++; last = i;
            end
            if (rsp_valid[0]) begin
                rsps++;
                check("b2b_rdata", rsp_rdata[0], 32'hDEADBEEF);
            end
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        repeat (6) begin
            if (rsp_valid[0]) rsps++;
            @(negedge clk);
        end
        check("b2b_accepts", 32'(acc), 32'd4);
        check("b2b_rsps", 32'(rsps), 32'(acc));

        txn(0, 1, 32'h30, 32'hCAFEF00D, 4'hF, g);
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h30;
        req_wdata[0] = 32'h12345678; req_be[0] = 4'hF;
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst_s[0] = 1'b1;
        #1;
        check("rst_mid_ready", 32'(req_ready[0]), 32'd1);
        check("rst_mid_valid", 32'(rsp_valid[0]), 32'd0);
        @(negedge clk);
        rst_s[0] = 1'b0;
        seen = 0;
        repeat (8) begin
            if (rsp_valid[0]) seen++;
            @(negedge clk);
        end
        check("rst_no_rsp", 32'(seen), 32'd0);
        txn(0, 0, 32'h30, 32'h0, 4'h0, g);
        check("rst_dropped_store", g, 32'hCAFEF00D);

        txn(1, 1, 32'h8, 32'h0BADF00D, 4'hF, g);
        txn(1, 0, 32'h8, 32'h0, 4'h0, g);
        check("lat0_load", g, 32'h0BADF00D);

        for (int d = 0; d < 2; d++)
            repeat (30) begin
                int r;
                r = $urandom_range(0, 9);
                a = 32'($urandom_range(0, 15)) * 4;
                if (r == 7) a = a + 32'($urandom_range(1, 3));
                if (r == 8) a = 32'h400 + a + ($urandom() & 32'hFFFF_F000);
                txn(d, 1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)), g);
            end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
